multicycle_control: RTL and testbench

//  Multi-cycle control FSM sitting directly upstream of the datapath: it consumes Instr and Zero
//  and drives every datapath control input: PC_Sel, PC_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel,
//  ALU_Bin_sel, ALU_func and Mem_WrEn. It sequences each instruction through FETCH/DECODE/EXEC/
//  MEM/WB/BRANCH, retires exactly one instruction per pass, and traps on undefined opcodes.

---
 rtl/charis_pkg.sv | 41 ++++
 rtl/multicycle_control_if.sv | 33 +++
 rtl/instr_class_decode.sv | 69 ++++++
 rtl/multicycle_control.sv | 147 ++++++++++++++
 tb/tb_multicycle_control.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/charis_pkg.sv
// Shared definitions for the multi-cycle controller: opcode and ALU codes,
// FSM state encoding, instruction classes and the R-type func legality check.
package charis_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b100000;
  localparam logic [5:0] OP_ADDI  = 6'b110000;
  localparam logic [5:0] OP_ANDI  = 6'b110010;
  localparam logic [5:0] OP_ORI   = 6'b110011;
  localparam logic [5:0] OP_LI    = 6'b111000;
  localparam logic [5:0] OP_LUI   = 6'b111001;
  localparam logic [5:0] OP_LW    = 6'b001111;
  localparam logic [5:0] OP_LB    = 6'b000011;
  localparam logic [5:0] OP_SW    = 6'b011111;
  localparam logic [5:0] OP_SB    = 6'b000111;
  localparam logic [5:0] OP_BEQ   = 6'b000000;
  localparam logic [5:0] OP_BNE   = 6'b000001;
  localparam logic [5:0] OP_B     = 6'b111111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_BRANCH = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd6;

  typedef enum logic [2:0] {
    CL_RTYPE, CL_ALUI, CL_LOAD, CL_STORE, CL_BEQ, CL_BNE, CL_B, CL_ILLEGAL
  } iclass_e;

  function automatic logic rfunc_legal(input logic [3:0] f);
    return f inside {4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101,
                     4'b0110, 4'b1000, 4'b1001, 4'b1010, 4'b1100, 4'b1101};
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle.
//  Instr, Zero                : datapath -> controller
//  PC_Sel .. Byte_Op          : datapath control inputs
//  Illegal, Retire, Retired_Cnt: status
// master = controller side, slave = datapath side.
interface multicycle_control_if #(parameter int RETIRE_CNT_W = 32);
  logic [31:0]             Instr;
  logic                    Zero;
  logic                    PC_Sel;
  logic                    PC_LdEn;
  logic                    RF_WrEn;
  logic                    RF_WrData_sel;
  logic                    RF_B_sel;
  logic                    ALU_Bin_sel;
  logic [3:0]              ALU_func;
  logic                    Mem_WrEn;
  logic                    Byte_Op;
  logic                    Illegal;
  logic                    Retire;
  logic [RETIRE_CNT_W-1:0] Retired_Cnt;

  modport master (
    input  Instr, Zero,
    output PC_Sel, PC_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel, ALU_Bin_sel,
           ALU_func, Mem_WrEn, Byte_Op, Illegal, Retire, Retired_Cnt
  );

  modport slave (
    output Instr, Zero,
    input  PC_Sel, PC_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel, ALU_Bin_sel,
           ALU_func, Mem_WrEn, Byte_Op, Illegal, Retire, Retired_Cnt
  );
endinterface

// File: rtl/instr_class_decode.sv
// Combinational instruction classifier.
//  op_i, func_i   : latched opcode / R-type func
//  class_o        : instruction class
//  alu_func_o     : ALU operation for the EXEC..end phase
//  bin_sel_o      : ALU B input from immediate
//  b_sel_o        : read rd on port B (stores, beq, bne)
//  byte_op_o      : lb/sb
//  illegal_o      : undefined opcode or R-type func
module instr_class_decode
  import charis_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [3:0] func_i,
  output iclass_e    class_o,
  output logic [3:0] alu_func_o,
  output logic       bin_sel_o,
  output logic       b_sel_o,
  output logic       byte_op_o,
  output logic       illegal_o
);

  always_comb begin
    class_o    = CL_ILLEGAL;
    alu_func_o = ALU_ADD;
    bin_sel_o  = 1'b0;
    b_sel_o    = 1'b0;
    byte_op_o  = 1'b0;
    case (op_i)
      OP_RTYPE: if (rfunc_legal(func_i)) begin
        class_o    = CL_RTYPE;
        alu_func_o = func_i;
      end
      OP_ADDI, OP_LI, OP_LUI: begin
        class_o   = CL_ALUI;
        bin_sel_o = 1'b1;
      end
      OP_ANDI: begin
        class_o    = CL_ALUI;
        alu_func_o = ALU_AND;
        bin_sel_o  = 1'b1;
      end
      OP_ORI: begin
        class_o    = CL_ALUI;
        alu_func_o = ALU_OR;
        bin_sel_o  = 1'b1;
      end
      OP_LW, OP_LB: begin
        class_o   = CL_LOAD;
        bin_sel_o = 1'b1;
        byte_op_o = (op_i == OP_LB);
      end
      OP_SW, OP_SB: begin
        class_o   = CL_STORE;
        bin_sel_o = 1'b1;
        b_sel_o   = 1'b1;
        byte_op_o = (op_i == OP_SB);
      end
      OP_BEQ, OP_BNE: begin
        class_o    = (op_i == OP_BEQ) ? CL_BEQ : CL_BNE;
        alu_func_o = ALU_SUB;
        b_sel_o    = 1'b1;
      end
      OP_B: class_o = CL_B;
      default: ;
    endcase
    illegal_o = (class_o == CL_ILLEGAL);
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM driving the datapath control inputs.
//  Clk, Reset : clock, synchronous active-high reset
//  bus        : controller side of multicycle_control_if (Instr/Zero in,
//               datapath controls and Illegal/Retire/Retired_Cnt out)
// Params: ILLEGAL_TRAP (1: sticky trap on undefined opcode, 0: NOP),
//         RETIRE_CNT_W (retired-instruction counter width).
module multicycle_control
  import charis_pkg::*;
#(
  parameter bit ILLEGAL_TRAP = 1'b1,
  parameter int RETIRE_CNT_W = 32
) (
  input  logic                 Clk,
  input  logic                 Reset,
  multicycle_control_if.master bus
);

  logic [2:0]              state_q, state_d;
  logic [5:0]              op_q;
  logic [3:0]              func_q;
  logic                    zero_q;
  logic [RETIRE_CNT_W-1:0] cnt_q, cnt_d;

  iclass_e    cls;
  logic [3:0] dec_alu;
  logic       dec_bin, dec_bsel, dec_byte, dec_ill;

  // only opcode and func bits steer control
  logic unused_instr;
  assign unused_instr = ^bus.Instr[25:4];

  instr_class_decode u_dec (
    .op_i      (op_q),
    .func_i    (func_q),
    .class_o   (cls),
    .alu_func_o(dec_alu),
    .bin_sel_o (dec_bin),
    .b_sel_o   (dec_bsel),
    .byte_op_o (dec_byte),
    .illegal_o (dec_ill)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (cls == CL_B)                  state_d = S_BRANCH;
        else if (dec_ill && ILLEGAL_TRAP) state_d = S_TRAP;
        else                              state_d = S_EXEC;
      end
      S_EXEC: begin
        if (cls == CL_LOAD || cls == CL_STORE)   state_d = S_MEM;
        else if (cls == CL_BEQ || cls == CL_BNE) state_d = S_BRANCH;
        else                                     state_d = S_WB;
      end
      S_MEM:    state_d = (cls == CL_LOAD) ? S_WB : S_FETCH;
      S_WB:     state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
  end

  logic       pc_sel, pc_ld, rf_wr, wd_sel, b_sel, bin_sel, mem_wr, byte_op;
  logic       illegal, retire;
  logic [3:0] alu_f;
  logic       in_instr, alu_phase;

  // FETCH still holds the previous op_q, so decoded controls start at DECODE
  assign in_instr  = state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB, S_BRANCH};
  assign alu_phase = state_q inside {S_EXEC, S_MEM, S_WB, S_BRANCH};

  always_comb begin
    pc_sel  = 1'b0;
    pc_ld   = 1'b0;
    rf_wr   = 1'b0;
    wd_sel  = 1'b0;
    mem_wr  = 1'b0;
    retire  = 1'b0;
    illegal = (state_q == S_TRAP);
    b_sel   = in_instr & dec_bsel;
    byte_op = in_instr & dec_byte;
    bin_sel = alu_phase & dec_bin;
    alu_f   = alu_phase ? dec_alu : ALU_ADD;
    case (state_q)
      S_MEM: if (cls == CL_STORE) begin
        mem_wr = 1'b1;
        pc_ld  = 1'b1;
        retire = 1'b1;
      end
      S_WB: begin
        rf_wr  = (cls != CL_ILLEGAL);  // non-trapping illegal is a NOP
        wd_sel = (cls == CL_LOAD);
        pc_ld  = 1'b1;
        retire = 1'b1;
      end
      S_BRANCH: begin
        pc_ld  = 1'b1;
        retire = 1'b1;
        pc_sel = (cls == CL_B) | ((cls == CL_BEQ) & zero_q) | ((cls == CL_BNE) & ~zero_q);
      end
      default: ;
    endcase
    // reset abandons the current instruction without side effects
    if (Reset) begin
      pc_ld  = 1'b0;
      rf_wr  = 1'b0;
      mem_wr = 1'b0;
      retire = 1'b0;
    end
  end

  assign cnt_d = retire ? cnt_q + RETIRE_CNT_W'(1) : cnt_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      func_q  <= '0;
      zero_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_FETCH) begin
        op_q   <= bus.Instr[31:26];
        func_q <= bus.Instr[3:0];
      end
      if (state_q == S_EXEC) zero_q <= bus.Zero;
      cnt_q <= cnt_d;
    end
  end

  assign bus.PC_Sel        = pc_sel;
  assign bus.PC_LdEn       = pc_ld;
  assign bus.RF_WrEn       = rf_wr;
  assign bus.RF_WrData_sel = wd_sel;
  assign bus.RF_B_sel      = b_sel;
  assign bus.ALU_Bin_sel   = bin_sel;
  assign bus.ALU_func      = alu_f;
  assign bus.Mem_WrEn      = mem_wr;
  assign bus.Byte_Op       = byte_op;
  assign bus.Illegal       = illegal;
  assign bus.Retire        = retire;
  assign bus.Retired_Cnt   = cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: two instances (trap / NOP on illegal, 32-bit /
// 4-bit retire counter) share Instr/Zero/Reset. Expected control vectors come
// from a per-instruction cycle-index model of the instruction-class rules.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        zero;
  int          nchk = 0;
  int          nerr = 0;
  logic [31:0] mc0;
  logic [3:0]  mc1;

  always #5 clk = ~clk;

  multicycle_control_if #(.RETIRE_CNT_W(32)) if0 ();
  multicycle_control_if #(.RETIRE_CNT_W(4))  if1 ();

  assign if0.Instr = instr;
  assign if0.Zero  = zero;
  assign if1.Instr = instr;
  assign if1.Zero  = zero;

  multicycle_control #(.ILLEGAL_TRAP(1'b1), .RETIRE_CNT_W(32)) u0 (
    .Clk(clk), .Reset(rst), .bus(if0.master));
  multicycle_control #(.ILLEGAL_TRAP(1'b0), .RETIRE_CNT_W(4)) u1 (
    .Clk(clk), .Reset(rst), .bus(if1.master));

  // [13]PC_Sel [12]PC_LdEn [11]RF_WrEn [10]RF_WrData_sel [9]RF_B_sel
  // [8]ALU_Bin_sel [7:4]ALU_func [3]Mem_WrEn [2]Byte_Op [1]Illegal [0]Retire
  logic [13:0] o0, o1;
  assign o0 = {if0.PC_Sel, if0.PC_LdEn, if0.RF_WrEn, if0.RF_WrData_sel, if0.RF_B_sel,
               if0.ALU_Bin_sel, if0.ALU_func, if0.Mem_WrEn, if0.Byte_Op, if0.Illegal, if0.Retire};
  assign o1 = {if1.PC_Sel, if1.PC_LdEn, if1.RF_WrEn, if1.RF_WrData_sel, if1.RF_B_sel,
               if1.ALU_Bin_sel, if1.ALU_func, if1.Mem_WrEn, if1.Byte_Op, if1.Illegal, if1.Retire};

  localparam int CR = 0, CALUI = 1, CLD = 2, CST = 3, CBEQ = 4, CBNE = 5, CB = 6, CILL = 7;

  function automatic int cls_of(input logic [31:0] ins);
    case (ins[31:26])
      6'b100000: return (ins[3:0] inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
                                          4'd8, 4'd9, 4'd10, 4'd12, 4'd13}) ? CR : CILL;
      6'b110000, 6'b110010, 6'b110011, 6'b111000, 6'b111001: return CALUI;
      6'b001111, 6'b000011: return CLD;
      6'b011111, 6'b000111: return CST;
      6'b000000: return CBEQ;
      6'b000001: return CBNE;
      6'b111111: return CB;
      default:   return CILL;
    endcase
  endfunction

  function automatic int lat(input logic [31:0] ins);
    case (cls_of(ins))
      CLD:     return 5;
      CB:      return 3;
      default: return 4;
    endcase
  endfunction

  // Expected controls in cycle k (1 = fetch) of one instruction; z is Zero in cycle 3.
  function automatic logic [13:0] expv(input logic [31:0] ins, input logic z,
                                       input logic trap, input int k);
    int c, n;
    logic [13:0] v;
    logic [5:0]  op;
    logic [3:0]  af;
    logic        bin;
    c = cls_of(ins); n = lat(ins); v = '0; op = ins[31:26];
    af = 4'd0; bin = 1'b0;
    if (k <= 1) return v;
    if (c == CILL && trap) begin
      if (k >= 3) v[1] = 1'b1;
      return v;
    end
    v[9] = (c == CST || c == CBEQ || c == CBNE);
    v[2] = (op == 6'b000011 || op == 6'b000111);
    case (c)
      CR: af = ins[3:0];
      CALUI: begin
        bin = 1'b1;
        if (op == 6'b110010) af = 4'b0010;
        else if (op == 6'b110011) af = 4'b0011;
      end
      CLD, CST: bin = 1'b1;
      CBEQ, CBNE: af = 4'b0001;
      default: ;
    endcase
    if (k >= 3) begin
      v[8]   = bin;
      v[7:4] = af;
    end
    if (k == n) begin
      v[12] = 1'b1;
      v[0]  = 1'b1;
      v[11] = (c == CR || c == CALUI || c == CLD);
      v[10] = (c == CLD);
      v[3]  = (c == CST);
      v[13] = (c == CB) ? 1'b1 : (c == CBEQ) ? z : (c == CBNE) ? ~z : 1'b0;
    end
    return v;
  endfunction

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [3:0] f);
    return {op, 22'h12345, f};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    mc0 = '0;
    mc1 = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; instr = mk(6'b100000, 4'd0); zero = 1'b0;
    @(posedge clk); #1;
    nchk += 4;
    if (o0 !== 14'd0) begin nerr++; $display("FAIL reset_ctl0 got=%h exp=0", o0); end
    if (o1 !== 14'd0) begin nerr++; $display("FAIL reset_ctl1 got=%h exp=0", o1); end
    if (if0.Retired_Cnt !== 32'd0) begin nerr++; $display("FAIL reset_cnt0 got=%0d exp=0", if0.Retired_Cnt); end
    if (if1.Retired_Cnt !== 4'd0) begin nerr++; $display("FAIL reset_cnt1 got=%0d exp=0", if1.Retired_Cnt); end
    @(posedge clk); #1;
    rst = 1'b0; mc0 = '0; mc1 = '0;
  endtask

  task automatic test_directed();
    logic [31:0] qi[$];
    logic        qz[$];
    logic [13:0] e0, e1;
    int          n;
    qi.push_back(mk(6'b100000, 4'd0));  qz.push_back(1'b0);  // add
    qi.push_back(mk(6'b100000, 4'd13)); qz.push_back(1'b1);
    qi.push_back(mk(6'b001111, 4'd0));  qz.push_back(1'b0);  // lw
    qi.push_back(mk(6'b000011, 4'd5));  qz.push_back(1'b0);  // lb
    qi.push_back(mk(6'b011111, 4'd0));  qz.push_back(1'b0);  // sw
    qi.push_back(mk(6'b000111, 4'd7));  qz.push_back(1'b1);  // sb
    qi.push_back(mk(6'b110000, 4'd9));  qz.push_back(1'b0);  // addi
    qi.push_back(mk(6'b110010, 4'd0));  qz.push_back(1'b0);  // andi
    qi.push_back(mk(6'b110011, 4'd0));  qz.push_back(1'b0);  // ori
    qi.push_back(mk(6'b111000, 4'd0));  qz.push_back(1'b0);  // li
    qi.push_back(mk(6'b111001, 4'd0));  qz.push_back(1'b0);  // lui
    qi.push_back(mk(6'b000000, 4'd0));  qz.push_back(1'b1);  // beq taken
    qi.push_back(mk(6'b000000, 4'd0));  qz.push_back(1'b0);  // beq not taken
    qi.push_back(mk(6'b000001, 4'd0));  qz.push_back(1'b0);  // bne taken
    qi.push_back(mk(6'b000001, 4'd0));  qz.push_back(1'b1);  // bne not taken
    qi.push_back(mk(6'b111111, 4'd0));  qz.push_back(1'b0);  // b
    qi.push_back(32'h0);                qz.push_back(1'b1);  // all-zero NOP
    for (int i = 0; i < qi.size(); i++) begin
      instr = qi[i]; zero = qz[i]; n = lat(instr);
      for (int k = 1; k <= n; k++) begin
        @(negedge clk);
        e0 = expv(instr, zero, 1'b1, k); e1 = expv(instr, zero, 1'b0, k);
        nchk += 4;
        if (o0 !== e0) begin nerr++; $display("FAIL dir_ctl0 i=%0d k=%0d got=%h exp=%h", i, k, o0, e0); end
        if (o1 !== e1) begin nerr++; $display("FAIL dir_ctl1 i=%0d k=%0d got=%h exp=%h", i, k, o1, e1); end
        if (if0.Retired_Cnt !== mc0) begin nerr++; $display("FAIL dir_cnt0 i=%0d got=%0d exp=%0d", i, if0.Retired_Cnt, mc0); end
        if (if1.Retired_Cnt !== mc1) begin nerr++; $display("FAIL dir_cnt1 i=%0d got=%0d exp=%0d", i, if1.Retired_Cnt, mc1); end
        @(posedge clk); #1;
        if (e0[0]) mc0++;
        if (e1[0]) mc1++;
      end
    end
  endtask

  // Zero is re-randomised every cycle: only its value in cycle 3 may matter.
  task automatic test_random();
    logic [5:0]  ops[13] = '{6'b100000, 6'b110000, 6'b110010, 6'b110011, 6'b111000,
                             6'b111001, 6'b001111, 6'b000011, 6'b011111, 6'b000111,
                             6'b000000, 6'b000001, 6'b111111};
    logic [3:0]  fl[12]  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9,
                             4'd10, 4'd12, 4'd13};
    logic [5:0]  op;
    logic [13:0] e0, e1;
    logic        z3;
    int          n;
    for (int i = 0; i < 60; i++) begin
      op    = ops[$urandom_range(12)];
      instr = {op, 22'($urandom), (op == 6'b100000) ? fl[$urandom_range(11)] : 4'($urandom)};
      n = lat(instr); z3 = 1'b0;
      for (int k = 1; k <= n; k++) begin
        zero = 1'($urandom);
        if (k == 3) z3 = zero;
        @(negedge clk);
        e0 = expv(instr, z3, 1'b1, k); e1 = expv(instr, z3, 1'b0, k);
        nchk += 4;
        if (o0 !== e0) begin nerr++; $display("FAIL rnd_ctl0 ins=%h k=%0d got=%h exp=%h", instr, k, o0, e0); end
        if (o1 !== e1) begin nerr++; $display("FAIL rnd_ctl1 ins=%h k=%0d got=%h exp=%h", instr, k, o1, e1); end
        if (if0.Retired_Cnt !== mc0) begin nerr++; $display("FAIL rnd_cnt0 got=%0d exp=%0d", if0.Retired_Cnt, mc0); end
        if (if1.Retired_Cnt !== mc1) begin nerr++; $display("FAIL rnd_cnt1 got=%0d exp=%0d", if1.Retired_Cnt, mc1); end
        @(posedge clk); #1;
        if (e0[0]) mc0++;
        if (e1[0]) mc1++;
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    instr = mk(6'b110000, 4'd0); zero = 1'b0;
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < 4; k++) begin @(posedge clk); #1; end
      if (i == 14) begin
        nchk++;
        if (if1.Retired_Cnt !== 4'hF) begin nerr++; $display("FAIL wrap_max got=%0d exp=15", if1.Retired_Cnt); end
      end
    end
    nchk += 2;
    if (if1.Retired_Cnt !== 4'h0) begin nerr++; $display("FAIL wrap_zero got=%0d exp=0", if1.Retired_Cnt); end
    if (if0.Retired_Cnt !== 32'd16) begin nerr++; $display("FAIL wrap_cnt0 got=%0d exp=16", if0.Retired_Cnt); end
    mc0 = 32'd16; mc1 = 4'd0;
  endtask

  task automatic test_reset_mid();
    instr = mk(6'b011111, 4'd0); zero = 1'b0;
    for (int k = 1; k <= 3; k++) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(negedge clk);
    nchk += 5;
    if (if0.ALU_Bin_sel !== 1'b1) begin nerr++; $display("FAIL rmid_inmem got=%b exp=1", if0.ALU_Bin_sel); end
    if ({if0.Mem_WrEn, if0.PC_LdEn, if0.RF_WrEn, if0.Retire} !== 4'b0)
      begin nerr++; $display("FAIL rmid_en0 got=%b exp=0000", {if0.Mem_WrEn, if0.PC_LdEn, if0.RF_WrEn, if0.Retire}); end
    if ({if1.Mem_WrEn, if1.PC_LdEn, if1.RF_WrEn, if1.Retire} !== 4'b0)
      begin nerr++; $display("FAIL rmid_en1 got=%b exp=0000", {if1.Mem_WrEn, if1.PC_LdEn, if1.RF_WrEn, if1.Retire}); end
    if (if0.Retired_Cnt !== 32'd16) begin nerr++; $display("FAIL rmid_cnt_pre got=%0d exp=16", if0.Retired_Cnt); end
    if (if0.Illegal !== 1'b0) begin nerr++; $display("FAIL rmid_ill got=%b exp=0", if0.Illegal); end
    @(posedge clk); #1;
    nchk += 3;
    if (o0 !== 14'd0) begin nerr++; $display("FAIL rmid_fetch0 got=%h exp=0", o0); end
    if (o1 !== 14'd0) begin nerr++; $display("FAIL rmid_fetch1 got=%h exp=0", o1); end
    if (if0.Retired_Cnt !== 32'd0) begin nerr++; $display("FAIL rmid_cnt0 got=%0d exp=0", if0.Retired_Cnt); end
    rst = 1'b0; mc0 = '0; mc1 = '0;
  endtask

  task automatic test_illegal();
    logic [31:0] qi[2] = '{mk(6'b101010, 4'd0), mk(6'b100000, 4'd7)};
    logic [13:0] e0, e1;
    for (int i = 0; i < 2; i++) begin
      instr = qi[i]; zero = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk);
        e0 = expv(instr, zero, 1'b1, k); e1 = expv(instr, zero, 1'b0, k);
        nchk += 2;
        if (o0 !== e0) begin nerr++; $display("FAIL ill_ctl0 i=%0d k=%0d got=%h exp=%h", i, k, o0, e0); end
        if (o1 !== e1) begin nerr++; $display("FAIL ill_ctl1 i=%0d k=%0d got=%h exp=%h", i, k, o1, e1); end
        @(posedge clk); #1;
        if (e1[0]) mc1++;
      end
      nchk++;
      if (if1.Retired_Cnt !== mc1) begin nerr++; $display("FAIL ill_nop_cnt1 got=%0d exp=%0d", if1.Retired_Cnt, mc1); end
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        nchk += 2;
        if (o0 !== 14'b10) begin nerr++; $display("FAIL ill_hold i=%0d c=%0d got=%h exp=2", i, k, o0); end
        if (if0.Retired_Cnt !== mc0) begin nerr++; $display("FAIL ill_cnt0 got=%0d exp=%0d", if0.Retired_Cnt, mc0); end
        @(posedge clk); #1;
      end
      do_reset();
      nchk++;
      if (if0.Illegal !== 1'b0) begin nerr++; $display("FAIL ill_clear got=%b exp=0", if0.Illegal); end
    end
  endtask

  initial begin
    rst = 1'b1; instr = '0; zero = 1'b0; mc0 = '0; mc1 = '0;
    test_reset();
    test_directed();
    test_random();
    test_wrap();
    test_reset_mid();
    test_illegal();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
